// File: rtl/decode_unit.sv
// Registered instruction decoder for the 8-bit accumulator CPU.
// Optional build macro: HALT_STICKY_EN (halt latches until clr).
module decode_unit (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] IR,
    output logic       halt,
    output logic [1:0] op,
    output logic       selA,
    output logic       loadA,
    output logic       selB,
    output logic       loadB
);

    typedef enum logic [1:0] {
        OpPass = 2'd0,
        OpAddAB = 2'd1,
        OpAddAA = 2'd2,
        OpAddBB = 2'd3
    } alu_op_e;

    logic       halt_q, halt_d;
    logic [1:0] op_q, op_d;
    logic       sel_a_q, sel_a_d;
    logic       load_a_q, load_a_d;
    logic       sel_b_q, sel_b_d;
    logic       load_b_q, load_b_d;

    logic       add_dst_b;
    logic       add_src_b;

    assign add_dst_b = IR[4];
    assign add_src_b = IR[2];

    always_comb begin
        halt_d   = 1'b0;
        op_d     = OpPass;
        sel_a_d  = 1'b0;
        load_a_d = 1'b0;
        sel_b_d  = 1'b0;
        load_b_d = 1'b0;
`ifdef HALT_STICKY_EN
        if (halt_q) begin
            // Halted: IR is ignored and every control stays inactive until clr.
            halt_d = 1'b1;
        end else begin
`else
        begin
`endif
            unique case (IR[7:6])
                2'b00: load_a_d = 1'b1;
                2'b01: load_b_d = 1'b1;
                2'b10: begin
                    if (add_dst_b) begin
                        sel_b_d  = 1'b1;
                        load_b_d = 1'b1;
                    end else begin
                        sel_a_d  = 1'b1;
                        load_a_d = 1'b1;
                    end
                    if (add_dst_b != add_src_b) begin
                        op_d = OpAddAB;
                    end else if (add_dst_b) begin
                        op_d = OpAddBB;
                    end else begin
                        op_d = OpAddAA;
                    end
                end
                2'b11: halt_d = 1'b1;
                default: halt_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            halt_q   <= 1'b0;
            op_q     <= OpPass;
            sel_a_q  <= 1'b0;
            load_a_q <= 1'b0;
            sel_b_q  <= 1'b0;
            load_b_q <= 1'b0;
        end else begin
            halt_q   <= halt_d;
            op_q     <= op_d;
            sel_a_q  <= sel_a_d;
            load_a_q <= load_a_d;
            sel_b_q  <= sel_b_d;
            load_b_q <= load_b_d;
        end
    end

    assign halt  = halt_q;
    assign op    = op_q;
    assign selA  = sel_a_q;
    assign loadA = load_a_q;
    assign selB  = sel_b_q;
    assign loadB = load_b_q;

endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit: directed sequence plus random IR against a
// behavioural model of the instruction set.
module tb_decode_unit;

    logic       clk;
    logic       clr;
    logic [7:0] IR;
    logic       halt;
    logic [1:0] op;
    logic       selA;
    logic       loadA;
    logic       selB;
    logic       loadB;

    int errors = 0;
    int checks = 0;
    bit halted_m = 1'b0;

    decode_unit dut (
        .clk  (clk),
        .clr  (clr),
        .IR   (IR),
        .halt (halt),
        .op   (op),
        .selA (selA),
        .loadA(loadA),
        .selB (selB),
        .loadB(loadB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {halt, op[1:0], selA, loadA, selB, loadB}
    function automatic logic [6:0] observed();
        return {halt, op, selA, loadA, selB, loadB};
    endfunction

    // Reference: decode of one instruction given whether the CPU already halted.
    function automatic logic [6:0] model(input logic [7:0] ir, input bit halted);
        int cls;
        int dst;
        int src;
        int opv;
        cls = int'(ir) / 64;
        dst = (int'(ir) / 16) % 2;
        src = (int'(ir) / 4) % 2;
`ifdef HALT_STICKY_EN
        if (halted) return 7'b1000000;
`else
        if (halted && 1'b0) return 7'b1000000;
`endif
        case (cls)
            0: return 7'b0000100;
            1: return 7'b0000001;
            2: begin
                if (dst != src) opv = 1;
                else if (dst == 1) opv = 3;
                else opv = 2;
                if (dst == 0) return {1'b0, 2'(opv), 4'b1100};
                else return {1'b0, 2'(opv), 4'b0011};
            end
            default: return 7'b1000000;
        endcase
    endfunction

    task automatic step(input logic [7:0] ir, input string name);
        logic [6:0] exp;
        @(negedge clk);
        IR = ir;
        exp = model(ir, halted_m);
`ifdef HALT_STICKY_EN
        if (int'(ir) / 64 == 3) halted_m = 1'b1;
`endif
        @(posedge clk);
        #1;
        checks++;
        if (observed() !== exp) begin
            errors++;
            $display("FAIL %s IR=%02h got=%07b want=%07b", name, ir, observed(), exp);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        IR = 8'h05;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (observed() !== 7'b0) begin
            errors++;
            $display("FAIL reset got=%07b want=%07b", observed(), 7'b0);
        end
        @(negedge clk);
        clr = 1'b0;
        halted_m = 1'b0;
        #1;
        checks++;
        if (observed() !== 7'b0) begin
            errors++;
            $display("FAIL reset_release got=%07b want=%07b", observed(), 7'b0);
        end
    endtask

    task automatic test_program();
        step(8'h05, "lda5");
        step(8'h6B, "ldb43");
        step(8'h84, "add_a_b");
        step(8'h80, "add_a_a");
        step(8'h90, "add_b_a");
        step(8'hBF, "add_ignored_bits");
    endtask

    task automatic test_halt();
        step(8'hFF, "halt");
        step(8'h05, "after_halt_lda");
        step(8'h9C, "after_halt_add");
    endtask

    task automatic test_async_clr();
        step(8'h84, "pre_clr");
        #2;
        clr = 1'b1;
        #1;
        checks++;
        if (observed() !== 7'b0) begin
            errors++;
            $display("FAIL async_clr got=%07b want=%07b", observed(), 7'b0);
        end
        IR = 8'h80;
        @(posedge clk);
        #1;
        checks++;
        if (observed() !== 7'b0) begin
            errors++;
            $display("FAIL clr_over_edge got=%07b want=%07b", observed(), 7'b0);
        end
        @(negedge clk);
        clr = 1'b0;
        halted_m = 1'b0;
        step(8'h9C, "add_b_b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clk);
                clr = 1'b1;
                #1;
                checks++;
                if (observed() !== 7'b0) begin
                    errors++;
                    $display("FAIL rand_clr got=%07b want=%07b", observed(), 7'b0);
                end
                #1;
                clr = 1'b0;
                halted_m = 1'b0;
            end
            step(8'($urandom), "random");
        end
    endtask

    initial begin
        clr = 1'b1;
        IR = 8'h00;
        test_reset();
        test_program();
        test_halt();
        test_async_clr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
